// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the sequencer command path: instruction width,
// ASCII control characters and the command parser state encoding.
package uart_cmd_parser_pkg;

    localparam int SEQ_INST_W = 16;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    typedef enum logic [1:0] {
        sIdle    = 2'd0,
        sCollect = 2'd1,
        sDrain   = 2'd2,
        sPend    = 2'd3
    } parse_state_t;

endpackage

// File: rtl/uart_hex_decode.sv
// Combinational character classifier for the command parser.
// Define UART_CMD_LOWER_HEX_EN to accept 'a'-'f' as hex digits.
module uart_hex_decode
    import uart_cmd_parser_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [3:0] o_nib,
    output logic       o_is_hex,
    output logic       o_is_term,
    output logic       o_is_esc
);

    always_comb begin
        o_nib     = 4'h0;
        o_is_hex  = 1'b0;
        o_is_term = (i_char == ASCII_CR) || (i_char == ASCII_LF);
        o_is_esc  = (i_char == ASCII_ESC);
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_is_hex = 1'b1;
            o_nib    = i_char[3:0];
        end else if (i_char >= 8'h41 && i_char <= 8'h46) begin
            // 'A'..'F' have low nibble 1..6
            o_is_hex = 1'b1;
            o_nib    = i_char[3:0] + 4'd9;
        end
`ifdef UART_CMD_LOWER_HEX_EN
        else if (i_char >= 8'h61 && i_char <= 8'h66) begin
            o_is_hex = 1'b1;
            o_nib    = i_char[3:0] + 4'd9;
        end
`endif
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles ASCII-hex command lines from the UART receiver into instruction
// words on a valid/ready handshake. Optional macro: UART_CMD_LOWER_HEX_EN.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int INST_W  = SEQ_INST_W,
    parameter int NUM_NIB = INST_W / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [INST_W-1:0] o_inst,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic              o_cmd_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(NUM_NIB + 1);

    parse_state_t      r_state, w_state_nx;
    logic [INST_W-1:0] r_shift, w_shift_nx, w_shifted;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [INST_W-1:0] r_inst, w_inst_nx;
    logic              r_inst_valid, w_inst_valid_nx;
    logic              r_cmd_err, w_cmd_err_nx;
    logic              r_overrun, w_overrun_nx;

    logic [3:0] w_nib;
    logic       w_is_hex, w_is_term, w_is_esc;
    logic       w_full;

    uart_hex_decode u_dec (
        .i_char    (i_rx_data),
        .o_nib     (w_nib),
        .o_is_hex  (w_is_hex),
        .o_is_term (w_is_term),
        .o_is_esc  (w_is_esc)
    );

    assign w_shifted = (r_shift << 4) | INST_W'(w_nib);
    assign w_full    = (r_cnt == CNT_W'(NUM_NIB));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= sIdle;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_shift      <= w_shift_nx;
            r_cnt        <= w_cnt_nx;
            r_inst       <= w_inst_nx;
            r_inst_valid <= w_inst_valid_nx;
            r_cmd_err    <= w_cmd_err_nx;
            r_overrun    <= w_overrun_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_shift_nx      = r_shift;
        w_cnt_nx        = r_cnt;
        w_inst_nx       = r_inst;
        w_inst_valid_nx = r_inst_valid;
        w_cmd_err_nx    = 1'b0;
        w_overrun_nx    = 1'b0;
        case (r_state)
            sIdle: begin
                // Terminators and ESC between lines are silently skipped
                if (i_rx_valid) begin
                    if (w_is_hex) begin
                        w_shift_nx = w_shifted;
                        w_cnt_nx   = CNT_W'(1);
                        w_state_nx = sCollect;
                    end else if (!w_is_term && !w_is_esc) begin
                        w_state_nx = sDrain;
                    end
                end
            end
            sCollect: begin
                if (i_rx_valid) begin
                    if (w_is_hex) begin
                        if (w_full) begin
                            w_state_nx = sDrain;
                        end else begin
                            w_shift_nx = w_shifted;
                            w_cnt_nx   = r_cnt + CNT_W'(1);
                        end
                    end else if (w_is_term) begin
                        if (w_full) begin
                            w_inst_nx       = r_shift;
                            w_inst_valid_nx = 1'b1;
                            w_state_nx      = sPend;
                        end else begin
                            w_cmd_err_nx = 1'b1;
                            w_state_nx   = sIdle;
                        end
                    end else if (w_is_esc) begin
                        w_cnt_nx   = '0;
                        w_state_nx = sIdle;
                    end else begin
                        w_state_nx = sDrain;
                    end
                end
            end
            sDrain: begin
                if (i_rx_valid) begin
                    if (w_is_term) begin
                        w_cmd_err_nx = 1'b1;
                        w_state_nx   = sIdle;
                    end else if (w_is_esc) begin
                        w_state_nx = sIdle;
                    end
                end
            end
            sPend: begin
                // No parsing while a word is outstanding, even on the accept cycle
                if (i_rx_valid) w_overrun_nx = 1'b1;
                if (i_inst_ready) begin
                    w_inst_valid_nx = 1'b0;
                    w_state_nx      = sIdle;
                end
            end
            default: w_state_nx = sIdle;
        endcase
    end

    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_cmd_err    = r_cmd_err & ~rst;
    assign o_overrun    = r_overrun & ~rst;
    assign o_busy       = (r_state != sIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed lines plus random line
// traffic checked cycle by cycle against a line-level reference model.
module tb_uart_cmd_parser;
    import uart_cmd_parser_pkg::*;

    localparam int INST_W  = SEQ_INST_W;
    localparam int NUM_NIB = INST_W / 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              inst_ready = 1'b0;
    logic [INST_W-1:0] inst;
    logic              inst_valid, cmd_err, overrun, busy;

    always #5 clk = ~clk;

    uart_cmd_parser dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_inst       (inst),
        .o_inst_valid (inst_valid),
        .i_inst_ready (inst_ready),
        .o_cmd_err    (cmd_err),
        .o_overrun    (overrun),
        .o_busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: pending word + characters of the current line
    logic [7:0]        m_line[$];
    logic              m_vld = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
    logic [INST_W-1:0] m_inst = '0;

    // observed DUT activity, cleared per directed section
    int                n_acc, n_err, n_ovr, n_vld_cyc;
    logic [INST_W-1:0] last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hex_val(input logic [7:0] c, output int v);
        v = 0;
        if (c >= "0" && c <= "9") begin v = int'(c) - 48; return 1'b1; end
        if (c >= "A" && c <= "F") begin v = int'(c) - 55; return 1'b1; end
`ifdef UART_CMD_LOWER_HEX_EN
        if (c >= "a" && c <= "f") begin v = int'(c) - 87; return 1'b1; end
`endif
        return 1'b0;
    endfunction

    task automatic model_step(input logic v, input logic [7:0] d, input logic rdy, input logic rs);
        bit ok;
        int nv;
        logic [INST_W-1:0] val;
        m_err = 1'b0;
        m_ovr = 1'b0;
        if (rs) begin
            m_line.delete();
            m_vld  = 1'b0;
            m_inst = '0;
        end else if (m_vld) begin
            if (v) m_ovr = 1'b1;
            if (rdy) m_vld = 1'b0;
        end else if (v) begin
            if (d == ASCII_ESC) begin
                m_line.delete();
            end else if (d == ASCII_CR || d == ASCII_LF) begin
                if (m_line.size() > 0) begin
                    ok  = (m_line.size() == NUM_NIB);
                    val = '0;
                    foreach (m_line[i]) begin
                        if (!hex_val(m_line[i], nv)) ok = 1'b0;
                        val = val * 16 + INST_W'(nv);
                    end
                    if (ok) begin
                        m_vld  = 1'b1;
                        m_inst = val;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_line.delete();
                end
            end else begin
                m_line.push_back(d);
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic rs);
        rx_valid   = v;
        rx_data    = d;
        inst_ready = rdy;
        rst        = rs;
        if (inst_valid && rdy && !rs) begin
            n_acc++;
            last_acc = inst;
        end
        @(posedge clk);
        model_step(v, d, rdy, rs);
        #1;
        chk("valid", 32'(inst_valid), 32'(m_vld));
        if (m_vld) chk("inst", 32'(inst), 32'(m_inst));
        chk("cmd_err", 32'(cmd_err), 32'(m_err));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("busy", 32'(busy), 32'(m_vld || (m_line.size() > 0)));
        if (cmd_err) n_err++;
        if (overrun) n_ovr++;
        if (inst_valid) n_vld_cyc++;
    endtask

    task automatic send_line(input string s, input logic [7:0] t, input logic rdy);
        for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i], rdy, 1'b0);
        cyc(1'b1, t, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic clr();
        n_acc = 0; n_err = 0; n_ovr = 0; n_vld_cyc = 0; last_acc = '0;
    endtask

    initial begin
        clr();
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("rst_inst", 32'(inst), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        clr();
        send_line("12AB", ASCII_CR, 1'b1);
        idle(3, 1'b1);
        chk("t1_acc", 32'(n_acc), 1);
        chk("t1_word", 32'(last_acc), 32'h12AB);
        chk("t1_vld_cycles", 32'(n_vld_cyc), 1);
        chk("t1_err", 32'(n_err), 0);

        clr();
        send_line("12A", ASCII_LF, 1'b1);
        idle(2, 1'b1);
        chk("t2_err", 32'(n_err), 1);
        chk("t2_noinst", 32'(n_vld_cyc), 0);
        send_line("00FF", ASCII_CR, 1'b1);
        idle(2, 1'b1);
        chk("t2_word", 32'(last_acc), 32'h00FF);

        clr();
        send_line("1G34", ASCII_CR, 1'b1);
        send_line("12345", ASCII_CR, 1'b1);
        idle(2, 1'b1);
        chk("t3_err", 32'(n_err), 2);
        chk("t3_noinst", 32'(n_vld_cyc), 0);

        clr();
        send_line("BEEF", ASCII_CR, 1'b0);
        send_line("1", ASCII_CR, 1'b0);
        idle(2, 1'b0);
        chk("t4_ovr", 32'(n_ovr), 2);
        chk("t4_hold", 32'(inst), 32'hBEEF);
        chk("t4_hold_vld", 32'(inst_valid), 1);
        idle(2, 1'b1);
        chk("t4_acc", 32'(last_acc), 32'hBEEF);
        chk("t4_idle", 32'(busy), 0);
        send_line("0001", ASCII_CR, 1'b1);
        idle(2, 1'b1);
        chk("t4_word", 32'(last_acc), 32'h0001);
        chk("t4_acc_n", 32'(n_acc), 2);

        clr();
        send_line("ab12", ASCII_CR, 1'b1);
        idle(2, 1'b1);
`ifdef UART_CMD_LOWER_HEX_EN
        chk("t5_word", 32'(last_acc), 32'hAB12);
        chk("t5_err", 32'(n_err), 0);
`else
        chk("t5_err", 32'(n_err), 1);
        chk("t5_noinst", 32'(n_acc), 0);
`endif

        clr();
        cyc(1'b1, 8'h31, 1'b1, 1'b0);
        cyc(1'b1, 8'h32, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        send_line("34", ASCII_CR, 1'b1);
        idle(2, 1'b1);
        chk("t6_err", 32'(n_err), 1);
        chk("t6_noinst", 32'(n_vld_cyc), 0);

        // random line traffic with gaps, junk, ESC, back-pressure and resets
        for (int ln = 0; ln < 400; ln++) begin
            string hexs;
            int    len;
            logic [7:0] c, t;
            hexs = "0123456789ABCDEFabcdef";
            len  = ($urandom % 2) ? NUM_NIB : int'($urandom_range(0, NUM_NIB + 2));
            for (int i = 0; i < len; i++) begin
                case ($urandom % 20)
                    0:       c = ASCII_ESC;
                    1:       c = 8'($urandom);
                    2:       c = "G";
                    default: c = hexs[$urandom % 22];
                endcase
                while ($urandom % 4 == 0) cyc(1'b0, 8'($urandom), 1'($urandom % 3 != 0), 1'b0);
                cyc(1'b1, c, 1'($urandom % 3 != 0), ($urandom % 300 == 0));
            end
            t = ($urandom % 2) ? ASCII_CR : ASCII_LF;
            cyc(1'b1, t, 1'($urandom % 3 != 0), 1'b0);
            if ($urandom % 3 == 0) cyc(1'b1, ASCII_LF, 1'($urandom % 2), 1'b0);
            idle(int'($urandom_range(0, 3)), 1'($urandom % 3 != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Receive-side companion to the UART transmit/dump path.
- Consumes the byte stream from the UART receiver (rx_byte / received strobe) and assembles ASCII-hex command lines into fixed-width instruction words for the sequencer.
- Presents each complete word on a valid/ready handshake, and flags malformed lines and dropped bytes.

Parameters:
- INST_W, 16, instruction width in bits; must be a multiple of 4.
- NUM_NIB, INST_W/4, hex digits required per command line.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- i_rx_data  input  8  received byte from UART.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_inst  output  INST_W  assembled instruction word.
- o_inst_valid  output  1  instruction available; held until accepted.
- i_inst_ready  input  1  consumer accepts when o_inst_valid && i_inst_ready.
- o_cmd_err  output  1  one-cycle pulse: line terminated with bad content.
- o_overrun  output  1  one-cycle pulse: byte dropped while an instruction is pending.
- o_busy  output  1  high when state != sIdle.

Behaviour:
- Reset values:
  - o_inst = 0, o_inst_valid = 0, o_cmd_err = 0, o_overrun = 0.
  - State = sIdle; shift register = 0; nibble count = 0.
- Character classes:
  - HEX: '0'-'9' and 'A'-'F'.
  - TERM: '\r' (0x0D) or '\n' (0x0A).
  - ESC: 0x1B.
  - Everything else is INVALID.
- States:
  - sIdle: HEX → shift nibble into LSBs (shift register << 4), count = 1, go to sCollect. TERM → ignore, no error (covers CR/LF pairs and blank lines). ESC → ignore. INVALID → go to sDrain.
  - sCollect: HEX with count < NUM_NIB → shift in, count++. HEX with count == NUM_NIB → go to sDrain (too many digits). TERM with count == NUM_NIB → load o_inst from the shift register, assert o_inst_valid, go to sPend. TERM with count < NUM_NIB → pulse o_cmd_err, go to sIdle. ESC → clear count, go to sIdle, no error. INVALID → go to sDrain.
  - sDrain: discard bytes until TERM, then pulse o_cmd_err and go to sIdle. ESC → go to sIdle without error.
  - sPend: o_inst_valid stays high and o_inst stays stable until the handshake. On handshake, deassert o_inst_valid next cycle and go to sIdle. Any i_rx_valid while in sPend drops the byte and pulses o_overrun. This holds even in the handshake cycle; the byte is not parsed.
- Timing:
  - o_inst_valid rises the cycle after the terminating byte's strobe (latency 1).
  - All transitions are taken only on cycles with i_rx_valid = 1, except sPend exit.
- Shift register width is INST_W; bits shifted out the top are discarded.
- Reset mid-line: partial data discarded, no error pulse.
- o_cmd_err and o_overrun never assert in the same cycle as rst.

Optional Feature:
- Macro UART_CMD_LOWER_HEX_EN.
- Defined: 'a'-'f' are classified HEX with values 0xA-0xF.
- Undefined: 'a'-'f' are INVALID, so a line containing them ends in sDrain and then o_cmd_err.

Decomposition:
- ASCII constants (CR, LF, ESC) and state encodings go into the shared definitions include, next to the sequencer width definitions.
- INST_W defaults to the sequencer instruction width from that include.
- One natural sub-module, uart_hex_decode (combinational):
  - Input: 8-bit char.
  - Outputs: 4-bit nib, is_hex, is_term, is_esc.
  - Honours UART_CMD_LOWER_HEX_EN.
- The FSM and datapath stay in uart_cmd_parser.

Test Plan:
- Send "12AB\r" with i_inst_ready = 1 → o_inst = 0x12AB, o_inst_valid high for exactly 1 cycle, starting 1 cycle after the '\r' strobe; no error.
- Send "12A\n" → o_cmd_err pulses once, o_inst_valid never rises. Then send "00FF\r" → o_inst = 0x00FF.
- Send "1G34\r" then "12345\r" → two o_cmd_err pulses, one per line terminator, no instruction issued.
- Send "BEEF\r" with i_inst_ready = 0, then "1\r" → o_inst stays 0xBEEF, o_overrun pulses twice. Raise ready → accept 0xBEEF, return to idle; a subsequent "0001\r" yields 0x0001.
- Send "ab12\r":
  - Macro defined → o_inst = 0xAB12.
  - Macro undefined → o_cmd_err pulses once.
- Send "12", assert rst for 1 cycle, then send "34\r" → o_cmd_err pulses (only 2 digits), and no stale digits appear.
